ex_result_skid_buf: RTL and testbench
=====================================

Name: ex_result_skid_buf

Overview:
- Two-entry elastic buffer directly downstream of the ALU: captures each ALU result Y together with its destination register index and write-back enable, and hands it to the memory/write-back stage over a valid/ready handshake.
- Decouples ALU timing from memory-stage stalls without losing results.
- Exposes the head entry as a forwarding source for operand hazard resolution.
- Supports a synchronous pipeline flush on branch/trap redirect.

Parameters:
- DATA_W, 32, width of ALU result path.
- RD_W, 5, width of destination register index.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  buffer can accept an entry this cycle
- in_result  input  DATA_W  ALU result Y
- in_rd  input  RD_W  destination register index
- in_wb_en  input  1  register write-back requested
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_result  output  DATA_W  head entry result
- out_rd  output  RD_W  head entry destination
- out_wb_en  output  1  head entry write enable
- fwd_valid  output  1  head entry is a usable forwarding source
- fwd_rd  output  RD_W  forwarding destination index (equals out_rd)
- fwd_data  output  DATA_W  forwarding data (equals out_result)
- occupancy  output  2  number of held entries, 0..2

Behaviour:
- Storage: head register (drives out_*) and skid register; state EMPTY / ONE / TWO; occupancy = 0 / 1 / 2.
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0; out_result=0; out_rd=0; out_wb_en=0; skid contents=0; fwd_valid=0; occupancy=0; in_ready=1.
- Handshakes:
  - in_ready = (state != TWO), combinational from state only; no dependence on out_ready.
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
- Latency: entry accepted at edge N appears on out_* immediately after edge N when the buffer was empty or the head fired the same cycle.
- Transitions:
  - EMPTY: accept -> ONE, head <= in.
  - ONE: accept & fire -> ONE, head <= in. Accept & !fire -> TWO, skid <= in. !accept & fire -> EMPTY. Otherwise hold.
  - TWO: fire -> ONE, head <= skid. Otherwise hold. in_valid ignored because in_ready=0.
- Ordering: strict FIFO; an entry never overtakes an older one.
- Stability: while out_valid=1 and out_ready=0, out_result, out_rd and out_wb_en hold their values.
- Flush:
  - flush=1 at an edge -> state EMPTY, out_valid=0, head/skid payload cleared to 0.
  - Overrides any simultaneous accept and fire; the input presented that cycle is dropped.
  - A downstream fire in the flush cycle still counts as consumed by the downstream stage.
  - in_ready is not masked by flush.
- Forwarding: fwd_valid = out_valid & out_wb_en & (out_rd != 0). Writes to x0 are never forwarded but still passed downstream unchanged. The skid entry is not forwarded.
- Width: payload passes through unmodified; no arithmetic.
- Reset mid-operation: all held entries discarded immediately; outputs take reset values without waiting for a clock edge.

Test Plan:
- Streaming: out_ready=1; present results 0x00000001..0x00000004, rd=1..4, wb_en=1, one per cycle -> each appears one cycle later in order; occupancy stays 1; in_ready stays 1; fwd_valid=1 with matching rd/data.
- Backpressure fill: out_ready=0; send 0xAAAA0000 (rd=5), then 0xBBBB0000 (rd=6) -> occupancy 2, in_ready=0, out_result holds 0xAAAA0000; a third in_valid with 0xCCCC0000 is not accepted. Raise out_ready -> 0xAAAA0000 then 0xBBBB0000; 0xCCCC0000 never appears.
- Simultaneous accept+fire in ONE: head 0x11111111; in_valid with 0x22222222 and out_ready=1 the same cycle -> next cycle head=0x22222222, occupancy 1.
- Flush: occupancy 2 (0xDEADBEEF, 0xCAFEF00D); assert flush with in_valid (0x12345678) -> next cycle occupancy 0, out_valid=0, 0x12345678 dropped; following input 0x0000000F appears normally.
- x0 write: in_rd=0, wb_en=1, result 0xFFFFFFFF -> out_valid=1, out_rd=0, fwd_valid=0. Same with rd=7, wb_en=0 -> fwd_valid=0.
- Async reset mid-stall: occupancy 2, drop rst_n between clock edges -> out_valid=0, occupancy=0, in_ready=1 immediately. Release, send 0x00000042 -> appears after one cycle.

Source files
------------

// File: rtl/ex_result_skid_buf_if.sv
// Handshake bundle between the ALU, the result skid buffer and the memory/write-back stage.
// The producer (ALU side) and consumer (memory side) are both driven through the master view.
interface ex_result_skid_buf_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    // Handshake rule for both sides: a transfer happens on a rising clock edge
    // exactly when valid and ready are both high; valid never waits on ready.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [RD_W-1:0]   in_rd;
    logic              in_wb_en;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_wb_en;

    modport master (
        output in_valid, in_result, in_rd, in_wb_en, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wb_en
    );

    modport slave (
        input  in_valid, in_result, in_rd, in_wb_en, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wb_en
    );
endinterface

// File: rtl/ex_result_skid_buf.sv
// Two-entry elastic buffer between the ALU and the memory/write-back stage.
// The head entry drives the downstream port and doubles as a forwarding source.
module ex_result_skid_buf #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    ex_result_skid_buf_if.slave bus,
    output logic                fwd_valid,
    output logic [RD_W-1:0]     fwd_rd,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [1:0]          occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              wb_en;
    } entry_t;

    // Encoding equals the entry count, so occupancy is a direct view of the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   fire;

    assign in_entry = '{result: bus.in_result, rd: bus.in_rd, wb_en: bus.in_wb_en};

    assign bus.in_ready  = (state_q != TWO);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid & bus.in_ready;
    assign fire          = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // A fire in this cycle is still consumed downstream; the input is dropped.
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_result = head_q.result;
    assign bus.out_rd     = head_q.rd;
    assign bus.out_wb_en  = head_q.wb_en;

    // x0 writes still travel downstream but must never be forwarded.
    assign fwd_valid = bus.out_valid & head_q.wb_en & (head_q.rd != '0);
    assign fwd_rd    = head_q.rd;
    assign fwd_data  = head_q.result;
    assign occupancy = state_q;

endmodule

// File: tb/tb_ex_result_skid_buf.sv
// Bench for ex_result_skid_buf: directed scenarios plus random traffic, checked
// against a bounded FIFO model held in the expected queue.
module tb_ex_result_skid_buf;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int W      = DATA_W + RD_W + 1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [1:0]        occupancy;

    ex_result_skid_buf_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus_if ();

    ex_result_skid_buf #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus_if),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    // The model is a FIFO of capacity two: ready while not full, head = oldest entry.
    always @(negedge clk) begin
        if (rst_n) begin
            logic         ready_m;
            logic         fire_m;
            logic [W-1:0] head;
            ready_m = (exp_q.size() < 2);
            fire_m  = (exp_q.size() != 0) && bus_if.out_ready;
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("in_ready", 64'(bus_if.in_ready), 64'(ready_m));
            chk("out_valid", 64'(bus_if.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                chk("out_payload", 64'({bus_if.out_result, bus_if.out_rd, bus_if.out_wb_en}), 64'(head));
                chk("fwd_valid", 64'(fwd_valid), 64'(head[0] && (head[RD_W:1] != '0)));
                chk("fwd_rd_data", 64'({fwd_data, fwd_rd}), 64'(head[W-1:1]));
            end else begin
                chk("fwd_valid_empty", 64'(fwd_valid), 64'(0));
            end
            if (fire_m) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (bus_if.in_valid && ready_m)
                exp_q.push_back({bus_if.in_result, bus_if.in_rd, bus_if.in_wb_en});
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r,
                         input logic w, input logic ordy, input logic fl);
        bus_if.in_valid  = v;
        bus_if.in_result = d;
        bus_if.in_rd     = r;
        bus_if.in_wb_en  = w;
        bus_if.out_ready = ordy;
        flush            = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            budget--;
        end
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst_n            = 1'b0;
        flush            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_result = '0;
        bus_if.in_rd     = '0;
        bus_if.in_wb_en  = 1'b0;
        bus_if.out_ready = 1'b0;
        #3;
        chk("reset_out_valid", 64'(bus_if.out_valid), 64'(0));
        chk("reset_in_ready", 64'(bus_if.in_ready), 64'(1));
        chk("reset_occupancy", 64'(occupancy), 64'(0));
        chk("reset_payload", 64'({bus_if.out_result, bus_if.out_rd, bus_if.out_wb_en}), 64'(0));
        chk("reset_fwd_valid", 64'(fwd_valid), 64'(0));
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DATA_W'(i), RD_W'(i), 1'b1, 1'b1, 1'b0);
            chk("stream_out", 64'({bus_if.out_result, bus_if.out_rd}), 64'({DATA_W'(i), RD_W'(i)}));
            chk("stream_fwd", 64'({fwd_valid, fwd_data, fwd_rd}), 64'({1'b1, DATA_W'(i), RD_W'(i)}));
        end
        drain("stream_drain");

        // Backpressure fill, third entry refused
        drive(1'b1, 32'hAAAA0000, 5'd5, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hBBBB0000, 5'd6, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hCCCC0000, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("bp_occupancy", 64'(occupancy), 64'(2));
        chk("bp_in_ready", 64'(bus_if.in_ready), 64'(0));
        chk("bp_hold", 64'(bus_if.out_result), 64'(32'hAAAA0000));
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("bp_second", 64'(bus_if.out_result), 64'(32'hBBBB0000));
        drain("bp_drain");

        // Accept and fire in the same cycle
        drive(1'b1, 32'h11111111, 5'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h22222222, 5'd2, 1'b1, 1'b1, 1'b0);
        chk("af_head", 64'(bus_if.out_result), 64'(32'h22222222));
        chk("af_occupancy", 64'(occupancy), 64'(1));
        drain("af_drain");

        // Flush from full with a simultaneous input
        drive(1'b1, 32'hDEADBEEF, 5'd8, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hCAFEF00D, 5'd9, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h12345678, 5'd3, 1'b1, 1'b0, 1'b1);
        chk("flush_state", 64'({bus_if.out_valid, occupancy}), 64'(0));
        chk("flush_payload", 64'({bus_if.out_result, bus_if.out_rd, bus_if.out_wb_en}), 64'(0));
        drive(1'b1, 32'h0000000F, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("post_flush", 64'({bus_if.out_valid, bus_if.out_result}), 64'({1'b1, 32'h0000000F}));
        drain("flush_drain");

        // x0 destination and disabled write-back are not forwarded
        drive(1'b1, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("x0_pass", 64'({bus_if.out_valid, bus_if.out_rd, fwd_valid}), 64'({1'b1, 5'd0, 1'b0}));
        drive(1'b1, 32'h00000077, 5'd7, 1'b0, 1'b1, 1'b0);
        chk("nowb_pass", 64'({bus_if.out_valid, bus_if.out_rd, fwd_valid}), 64'({1'b1, 5'd7, 1'b0}));
        drain("x0_drain");

        // Asynchronous reset while full and stalled
        drive(1'b1, 32'h00000051, 5'd10, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h00000052, 5'd11, 1'b1, 1'b0, 1'b0);
        bus_if.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_state", 64'({bus_if.out_valid, occupancy, bus_if.in_ready}), 64'({1'b0, 2'd0, 1'b1}));
        chk("async_rst_fwd", 64'({fwd_valid, bus_if.out_result}), 64'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h00000042, 5'd12, 1'b1, 1'b1, 1'b0);
        chk("post_reset", 64'({bus_if.out_valid, bus_if.out_result}), 64'({1'b1, 32'h00000042}));
        drain("reset_drain");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, RD_W'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
        end
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
